// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: the sequencer
// state encoding, the command codes on multControl/divControl and the
// default iteration count.
package mult_div_pkg;

   // Sequencer states of the multiply/divide unit
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MULT    = 3'd1,
      ST_DIV     = 3'd2,
      ST_SIGNFIX = 3'd3,
      ST_DONE    = 3'd4
   } mdState_t;

   // Command codes; 2'b11 is reserved and behaves like idle
   localparam logic [1:0] MD_IDLE  = 2'b00;
   localparam logic [1:0] MD_START = 2'b01;
   localparam logic [1:0] MD_ABORT = 2'b10;

   // Default operand width, which is also the number of iterations
   localparam int MD_ITER = 32;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step on unsigned magnitudes. The partial remainder
// is shifted left taking in the next dividend bit from the top of quo; if the
// divisor fits, it is subtracted and a 1 enters the quotient, otherwise the
// shifted remainder is kept and a 0 enters the quotient.
module md_div_step
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_ITER
)
(
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remNext,
   output logic [WIDTH-1:0] quoNext
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // Trial subtraction; the top bit of the difference tells whether it went negative
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         remNext = trial[WIDTH-1:0];
         quoNext = {quo[WIDTH-2:0], 1'b1};
      end else begin
         remNext = shifted[WIDTH-1:0];
         quoNext = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit for the multicycle CPU datapath.
// Multiply uses radix-2 Booth recoding, one step per clock, on a
// {P, Q, q-1} register where P carries one extra sign bit so that the most
// negative multiplicand cannot overflow the partial product. Divide runs
// restoring division on operand magnitudes and fixes the signs afterwards
// (quotient truncates toward zero, remainder follows the dividend).
// hi/lo are written only when an operation completes.
//
// Optional feature: define MULT_EARLY_EXIT_EN to let a multiply finish as
// soon as the remaining multiplier bits would only cause shifts.
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = MD_ITER
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       multControl,
   input  logic [1:0]       divControl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH + 1);

   mdState_t         state;
   logic [CW-1:0]    counter;

   logic [WIDTH:0]   mcand;
   logic [WIDTH:0]   pReg;
   logic [WIDTH-1:0] qReg;
   logic             qm1;

   logic [WIDTH-1:0] remReg;
   logic [WIDTH-1:0] quoReg;
   logic [WIDTH-1:0] divisorReg;
   logic             signA;
   logic             signB;
   logic             isDiv;
   logic             divZero;

   logic             abortReq;
   logic [WIDTH:0]   pSum;
   logic [2*WIDTH+1:0] boothShifted;
   logic [WIDTH-1:0] remNext;
   logic [WIDTH-1:0] quoNext;

   assign abortReq = (multControl == MD_ABORT) || (divControl == MD_ABORT);

   // Booth step: add or subtract the multiplicand per {Q0, q-1}, then shift the whole register right arithmetically
   always_comb begin
      pSum = pReg;
      case ({qReg[0], qm1})
         2'b01:   pSum = pReg + mcand;
         2'b10:   pSum = pReg - mcand;
         default: pSum = pReg;
      endcase
      boothShifted = {pSum[WIDTH], pSum, qReg};
   end

   md_div_step #(
      .WIDTH   (WIDTH)
   ) u_divStep (
      .rem     (remReg),
      .quo     (quoReg),
      .divisor (divisorReg),
      .remNext (remNext),
      .quoNext (quoNext)
   );

`ifdef MULT_EARLY_EXIT_EN
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]    pendMask;
   logic [WIDTH-1:0]    pendBits;
   logic                earlyExit;
   logic signed [2*WIDTH:0] exitShifted;

   // When the unprocessed multiplier bits and q-1 are uniform, every remaining step is a pure shift
   always_comb begin
      pendMask    = (ONE << counter) - ONE;
      pendBits    = qReg & pendMask;
      earlyExit   = ((pendBits == '0) && !qm1) || ((pendBits == pendMask) && qm1);
      exitShifted = $signed({pReg, qReg}) >>> counter;
   end
`endif

   // Sequencer: accepts commands in IDLE, iterates, fixes signs and commits hi/lo in DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         counter    <= '0;
         mcand      <= '0;
         pReg       <= '0;
         qReg       <= '0;
         qm1        <= 1'b0;
         remReg     <= '0;
         quoReg     <= '0;
         divisorReg <= '0;
         signA      <= 1'b0;
         signB      <= 1'b0;
         isDiv      <= 1'b0;
         divZero    <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         div0       <= 1'b0;
      end else begin
         done <= 1'b0;
         div0 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (multControl == MD_START) begin
                  mcand   <= {a[WIDTH-1], a};
                  pReg    <= '0;
                  qReg    <= b;
                  qm1     <= 1'b0;
                  counter <= CW'(WIDTH);
                  isDiv   <= 1'b0;
                  divZero <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_MULT;
               end else if (divControl == MD_START) begin
                  isDiv <= 1'b1;
                  if (b == '0) begin
                     divZero <= 1'b1;
                     state   <= ST_DONE;
                  end else begin
                     divZero    <= 1'b0;
                     signA      <= a[WIDTH-1];
                     signB      <= b[WIDTH-1];
                     remReg     <= '0;
                     quoReg     <= a[WIDTH-1] ? -a : a;
                     divisorReg <= b[WIDTH-1] ? -b : b;
                     counter    <= CW'(WIDTH);
                     busy       <= 1'b1;
                     state      <= ST_DIV;
                  end
               end
            end

            ST_MULT: begin
               if (abortReq) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
`ifdef MULT_EARLY_EXIT_EN
               else if (earlyExit) begin
                  pReg    <= exitShifted[2*WIDTH:WIDTH];
                  qReg    <= exitShifted[WIDTH-1:0];
                  qm1     <= 1'b0;
                  counter <= '0;
                  state   <= ST_DONE;
               end
`endif
               else begin
                  pReg    <= boothShifted[2*WIDTH+1:WIDTH+1];
                  qReg    <= boothShifted[WIDTH:1];
                  qm1     <= boothShifted[0];
                  counter <= counter - CW'(1);
                  if (counter == CW'(1)) begin
                     state <= ST_DONE;
                  end
               end
            end

            ST_DIV: begin
               if (abortReq) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  remReg  <= remNext;
                  quoReg  <= quoNext;
                  counter <= counter - CW'(1);
                  if (counter == CW'(1)) begin
                     state <= ST_SIGNFIX;
                  end
               end
            end

            ST_SIGNFIX: begin
               if (abortReq) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  if (signA ^ signB) begin
                     quoReg <= -quoReg;
                  end
                  if (signA) begin
                     remReg <= -remReg;
                  end
                  state <= ST_DONE;
               end
            end

            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
               if (divZero) begin
                  div0 <= 1'b1;
               end else if (isDiv) begin
                  hi <= remReg;
                  lo <= quoReg;
               end else begin
                  hi <= pReg[WIDTH-1:0];
                  lo <= qReg;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected results come from plain
// 64-bit signed arithmetic (product, truncating quotient, dividend-signed
// remainder); latencies come from the documented cycle counts.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   multControl;
   logic [1:0]   divControl;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         done;
   logic         div0;

   int           checks = 0;
   int           failures = 0;

   logic [W-1:0] expHi = '0;
   logic [W-1:0] expLo = '0;
   int           lat;
   logic         gotDone;
   logic         busyDropped;
   logic         div0Seen;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .multControl (multControl),
      .divControl  (divControl),
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .div0        (div0)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference: full signed product
   function automatic logic [63:0] modelMult(input logic [31:0] x, input logic [31:0] y);
      longint p;
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
   endfunction

   // Reference: {remainder, quotient} with truncation toward zero
   function automatic logic [63:0] modelDiv(input logic [31:0] x, input logic [31:0] y);
      longint sx;
      longint sy;
      longint q;
      longint r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   // Present a command for one clock; returns 1ns after the accepting edge
   task automatic applyStimulus(input logic [1:0] mc, input logic [1:0] dc,
                                input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      multControl = mc;
      divControl  = dc;
      a           = av;
      b           = bv;
      @(posedge clk);
      #1;
      multControl = 2'b00;
      divControl  = 2'b00;
   endtask

   // Count edges until done is seen, bounded by limit
   task automatic waitDone(input int limit);
      lat         = 0;
      gotDone     = 1'b0;
      busyDropped = 1'b0;
      div0Seen    = 1'b0;
      while (!gotDone && lat < limit) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            gotDone  = 1'b1;
            div0Seen = div0;
         end else if (!busy) begin
            busyDropped = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      reset       = 1'b1;
      multControl = 2'b01;
      divControl  = 2'b01;
      a           = 32'h0000_0005;
      b           = 32'h0000_0003;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (hi !== '0)   begin failures++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
      checks++; if (lo !== '0)   begin failures++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (div0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_div0: got %b expected 0", div0); end
      multControl = 2'b00;
      divControl  = 2'b00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed;
      // 7 * -3
      applyStimulus(2'b01, 2'b00, 32'd7, -32'sd3);
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mult_busy: got %b expected 1", busy); end
      waitDone(60);
      checks++; if (!gotDone) begin failures++; $display("[TB] FAIL mult_timeout: got no done expected done"); end
`ifdef MULT_EARLY_EXIT_EN
      checks++; if (lat < 2 || lat > 33) begin failures++; $display("[TB] FAIL mult_latency: got %0d expected 2..33", lat); end
`else
      checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL mult_latency: got %0d expected 33", lat); end
`endif
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("[TB] FAIL mult_7x-3: got %h%h expected FFFFFFFFFFFFFFEB", hi, lo); end
      checks++; if (div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL mult_div0: got %b expected 0", div0Seen); end
      checks++; if (busyDropped !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mult_busy_window: got dropped=%b end=%b expected 0 0", busyDropped, busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done); end

      // most negative squared
      applyStimulus(2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000);
      waitDone(60);
      checks++; if (!gotDone || {hi, lo} !== 64'h4000_0000_0000_0000) begin failures++; $display("[TB] FAIL mult_minsq: got %h%h done=%b expected 4000000000000000", hi, lo, gotDone); end

      // -7 / 2
      applyStimulus(2'b00, 2'b01, -32'sd7, 32'd2);
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL div_busy: got %b expected 1", busy); end
      waitDone(60);
      checks++; if (lat !== 34) begin failures++; $display("[TB] FAIL div_latency: got %0d expected 34", lat); end
      checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL div_-7/2: got hi=%h lo=%h expected hi=FFFFFFFF lo=FFFFFFFD", hi, lo); end
      expHi = 32'hFFFF_FFFF;
      expLo = 32'hFFFF_FFFD;

      // 5 / 0
      applyStimulus(2'b00, 2'b01, 32'd5, 32'd0);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL div0_busy: got %b expected 0", busy); end
      waitDone(10);
      checks++; if (lat !== 1 || !gotDone) begin failures++; $display("[TB] FAIL div0_latency: got %0d expected 1", lat); end
      checks++; if (div0Seen !== 1'b1) begin failures++; $display("[TB] FAIL div0_flag: got %b expected 1", div0Seen); end
      checks++; if (hi !== expHi || lo !== expLo) begin failures++; $display("[TB] FAIL div0_hold: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, expHi, expLo); end

      // overflow case of signed division
      applyStimulus(2'b00, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      waitDone(60);
      checks++; if (lo !== 32'h8000_0000 || hi !== '0 || div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL div_min/-1: got hi=%h lo=%h div0=%b expected hi=0 lo=80000000 div0=0", hi, lo, div0Seen); end

      // 9 * 1, short under early exit
      applyStimulus(2'b01, 2'b00, 32'd9, 32'd1);
      waitDone(60);
      checks++; if ({hi, lo} !== 64'd9) begin failures++; $display("[TB] FAIL mult_9x1: got %h%h expected 9", hi, lo); end
`ifdef MULT_EARLY_EXIT_EN
      checks++; if (lat >= 33) begin failures++; $display("[TB] FAIL mult_early_exit: got %0d expected below 33", lat); end
`else
      checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL mult_9x1_latency: got %0d expected 33", lat); end
`endif
      expHi = 32'd0;
      expLo = 32'd9;

      // both starts at once: mult wins
      applyStimulus(2'b01, 2'b01, 32'd6, 32'd2);
      waitDone(60);
      checks++; if ({hi, lo} !== 64'd12 || div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL both_start: got %h%h expected 12", hi, lo); end
      expLo = 32'd12;

      // reserved code acts as idle
      applyStimulus(2'b11, 2'b11, 32'd3, 32'd3);
      waitDone(6);
      checks++; if (gotDone !== 1'b0 || busy !== 1'b0 || lo !== expLo) begin failures++; $display("[TB] FAIL reserved_idle: got done=%b busy=%b lo=%h expected 0 0 %h", gotDone, busy, lo, expLo); end
   endtask

   task automatic test_random;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         isMult;
      logic [63:0]  ref64;
      for (int i = 0; i < 30; i++) begin
         x      = $urandom;
         y      = $urandom;
         isMult = 1'($urandom_range(0, 1));
         if (i % 5 == 1) y = W'($signed($urandom_range(0, 8)) - 4);
         if (i % 7 == 2) x = W'($urandom_range(0, 20));
         if (!isMult && i % 9 == 4) y = '0;
         applyStimulus(isMult ? 2'b01 : 2'b00, isMult ? 2'b00 : 2'b01, x, y);
         waitDone(60);
         if (isMult) begin
            ref64 = modelMult(x, y);
`ifdef MULT_EARLY_EXIT_EN
            checks++; if (!gotDone || lat < 2 || lat > 33) begin failures++; $display("[TB] FAIL rnd_mult_latency: got %0d expected 2..33", lat); end
`else
            checks++; if (!gotDone || lat !== 33) begin failures++; $display("[TB] FAIL rnd_mult_latency: got %0d expected 33", lat); end
`endif
            checks++; if ({hi, lo} !== ref64 || div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL rnd_mult %h*%h: got %h%h expected %h", x, y, hi, lo, ref64); end
            expHi = ref64[63:32];
            expLo = ref64[31:0];
         end else if (y == '0) begin
            checks++; if (!gotDone || lat !== 1 || div0Seen !== 1'b1 || hi !== expHi || lo !== expLo) begin failures++; $display("[TB] FAIL rnd_div0: got lat=%0d div0=%b hi=%h lo=%h expected 1 1 %h %h", lat, div0Seen, hi, lo, expHi, expLo); end
         end else begin
            ref64 = modelDiv(x, y);
            checks++; if (!gotDone || lat !== 34) begin failures++; $display("[TB] FAIL rnd_div_latency: got %0d expected 34", lat); end
            checks++; if (hi !== ref64[63:32] || lo !== ref64[31:0] || div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL rnd_div %h/%h: got hi=%h lo=%h expected hi=%h lo=%h", x, y, hi, lo, ref64[63:32], ref64[31:0]); end
            expHi = ref64[63:32];
            expLo = ref64[31:0];
         end
      end
   endtask

   task automatic test_reset_midop;
      applyStimulus(2'b01, 2'b00, 32'h0001_2345, 32'h0000_0777);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin failures++; $display("[TB] FAIL reset_midop: got busy=%b hi=%h lo=%h done=%b expected all 0", busy, hi, lo, done); end
      @(negedge clk);
      reset = 1'b0;
      waitDone(40);
      checks++; if (gotDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_no_done: got done expected none"); end
      expHi = '0;
      expLo = '0;
   endtask

   task automatic test_busy_ignore_and_abort;
      logic [63:0] ref64;
      ref64 = modelMult(32'h1234_5678, 32'hFFFF_F544);
      applyStimulus(2'b01, 2'b00, 32'h1234_5678, 32'hFFFF_F544);
      repeat (5) @(posedge clk);
      @(negedge clk);
      divControl  = 2'b01;
      multControl = 2'b01;
      a           = 32'd100;
      b           = 32'd0;
      @(negedge clk);
      divControl  = 2'b00;
      multControl = 2'b00;
      waitDone(60);
      checks++; if (!gotDone || {hi, lo} !== ref64 || div0Seen !== 1'b0) begin failures++; $display("[TB] FAIL busy_ignore: got %h%h expected %h", hi, lo, ref64); end
      waitDone(40);
      checks++; if (gotDone !== 1'b0) begin failures++; $display("[TB] FAIL busy_ignore_extra_done: got done expected none"); end

      // abort a divide part-way
      applyStimulus(2'b00, 2'b01, 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      multControl = 2'b10;
      @(posedge clk);
      #1;
      multControl = 2'b00;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL div_abort_busy: got %b expected 0", busy); end
      waitDone(45);
      checks++; if (gotDone !== 1'b0 || {hi, lo} !== ref64) begin failures++; $display("[TB] FAIL div_abort_hold: got done=%b %h%h expected 0 %h", gotDone, hi, lo, ref64); end

      // abort a multiply part-way
      applyStimulus(2'b01, 2'b00, 32'd3, 32'h7FFF_FFFF);
      repeat (4) @(posedge clk);
      @(negedge clk);
      divControl = 2'b10;
      @(negedge clk);
      divControl = 2'b00;
      waitDone(45);
      checks++; if (gotDone !== 1'b0 || {hi, lo} !== ref64 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mult_abort_hold: got done=%b %h%h expected 0 %h", gotDone, hi, lo, ref64); end
   endtask

   // Test sequence
   initial begin
      multControl = 2'b00;
      divControl  = 2'b00;
      a           = '0;
      b           = '0;
      reset       = 1'b0;
      test_reset;
      test_directed;
      test_random;
      test_reset_midop;
      test_busy_ignore_and_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
